pkt_disassembler: RTL and testbench

PKT_DISASSEMBLER -- requirements
Module: pkt_disassembler

---
 rtl/pkt_disassembler_pkg.sv | 45 ++++
 rtl/pkt_disassembler_key_field_extractor.sv | 27 ++
 rtl/pkt_disassembler.sv | 126 ++++++++++++
 tb/tb_pkt_disassembler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_disassembler_pkg.sv
// Shared constants and helpers for the packet disassembler: packet field
// positions, type code, counter width and the parity/shift functions.
package pkt_disassembler_pkg;

    localparam int PKT_BITS       = 72;
    localparam int KEY_W          = 32;
    localparam int SFT_W          = 6;
    localparam int CNT_W          = 16;
    localparam int NUM_DREGS_PIPE = 4;

    localparam int HDR_LSB  = 0;
    localparam int HDR_MSB  = 7;
    localparam int KEY_LSB  = 8;
    localparam int KEY_MSB  = 39;
    localparam int PAY_LSB  = 40;
    localparam int PAY_MSB  = 71;
    localparam int TYPE_LSB = 6;
    localparam int TYPE_MSB = 7;
    localparam int PAR_BIT  = 0;

    localparam logic [1:0]       MC_TYPE = 2'b00;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Whole-packet odd parity: the XOR across all bits must be one.
    function automatic logic odd_parity_ok(input logic [PKT_BITS-1:0] data);
        return (^data) == 1'b1;
    endfunction

    // Signed shift with zero fill; bit 5 set selects a left shift by the
    // magnitude of the two's complement, so 6'b100000 degenerates to zero.
    function automatic logic [KEY_W-1:0] signed_shift(input logic [KEY_W-1:0] val,
                                                      input logic [SFT_W-1:0] sft);
        logic [SFT_W-1:0] neg;
        logic [4:0]       amt;
        neg = 6'd0 - sft;
        if (sft[SFT_W-1]) begin
            amt = neg[4:0];
            return val << amt;
        end else begin
            amt = sft[4:0];
            return val >> amt;
        end
    endfunction

endpackage

// File: rtl/pkt_disassembler_key_field_extractor.sv
// Combinational event builder: masks the packet key per field, shifts each
// masked field and ORs the results together.
module key_field_extractor
    import pkt_disassembler_pkg::*;
#(
    parameter int NUM_FIELDS = NUM_DREGS_PIPE
) (
    input  logic [KEY_W-1:0]            i_key,
    input  logic [NUM_FIELDS*KEY_W-1:0] i_field_msk,
    input  logic [NUM_FIELDS*SFT_W-1:0] i_field_sft,
    output logic [KEY_W-1:0]            o_evt_data
);

    logic [KEY_W-1:0] w_acc;

    // Accumulate all shifted field contributions.
    always_comb begin
        w_acc = {KEY_W{1'b0}};
        for (int i = 0; i < NUM_FIELDS; i++) begin
            w_acc = w_acc | signed_shift(i_key & i_field_msk[i*KEY_W +: KEY_W],
                                         i_field_sft[i*SFT_W +: SFT_W]);
        end
    end

    assign o_evt_data = w_acc;

endmodule

// File: rtl/pkt_disassembler.sv
// Packet disassembler: filters packets on parity, type and key, extracts an
// event from the key and delivers it through a one-deep park buffer.
module pkt_disassembler
    import pkt_disassembler_pkg::*;
#(
    parameter int NUM_FIELDS = NUM_DREGS_PIPE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [KEY_W-1:0]            cfg_key_in,
    input  logic [KEY_W-1:0]            cfg_msk_in,
    input  logic [NUM_FIELDS*KEY_W-1:0] field_msk_in,
    input  logic [NUM_FIELDS*SFT_W-1:0] field_sft_in,
    input  logic [PKT_BITS-1:0]         pkt_data_in,
    input  logic                        pkt_vld_in,
    output logic                        pkt_rdy_out,
    output logic [KEY_W-1:0]            evt_data_out,
    output logic                        evt_vld_out,
    input  logic                        evt_rdy_in,
    output logic [CNT_W-1:0]            par_err_cnt_out,
    output logic [CNT_W-1:0]            drop_cnt_out
);

    logic             r_pkt_rdy;
    logic             r_evt_vld;
    logic [KEY_W-1:0] r_evt_data;
    logic             r_park_vld;
    logic [KEY_W-1:0] r_park_data;
    logic [CNT_W-1:0] r_par_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [KEY_W-1:0] w_key;
    logic [1:0]       w_type;
    logic             w_par_ok;
    logic             w_type_ok;
    logic             w_key_ok;
    logic             w_accept;
    logic             w_good;
    logic             w_par_err;
    logic             w_drop;
    logic             w_busy;
    logic             w_park_vld_nxt;
    logic [KEY_W-1:0] w_evt_data;

    assign w_key     = pkt_data_in[KEY_MSB:KEY_LSB];
    assign w_type    = pkt_data_in[TYPE_MSB:TYPE_LSB];
    assign w_par_ok  = odd_parity_ok(pkt_data_in);
    assign w_type_ok = (w_type == MC_TYPE);
    assign w_key_ok  = ((w_key & cfg_msk_in) == (cfg_key_in & cfg_msk_in));

    // Parity failures win over type/key failures so each drop counts once.
    assign w_accept  = pkt_vld_in & r_pkt_rdy;
    assign w_good    = w_accept & w_par_ok & w_type_ok & w_key_ok;
    assign w_par_err = w_accept & ~w_par_ok;
    assign w_drop    = w_accept & w_par_ok & ~(w_type_ok & w_key_ok);
    assign w_busy    = r_evt_vld & ~evt_rdy_in;

    key_field_extractor #(
        .NUM_FIELDS (NUM_FIELDS)
    ) u_extractor (
        .i_key       (w_key),
        .i_field_msk (field_msk_in),
        .i_field_sft (field_sft_in),
        .o_evt_data  (w_evt_data)
    );

    // Park occupancy for the next cycle; a free output always drains the park.
    always_comb begin
        w_park_vld_nxt = r_park_vld;
        if (w_busy) begin
            if (w_good) begin
                w_park_vld_nxt = 1'b1;
            end else begin
                w_park_vld_nxt = r_park_vld;
            end
        end else begin
            w_park_vld_nxt = 1'b0;
        end
    end

    // Handshake, output/park registers and saturating drop counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pkt_rdy   <= 1'b0;
            r_evt_vld   <= 1'b0;
            r_evt_data  <= {KEY_W{1'b0}};
            r_park_vld  <= 1'b0;
            r_park_data <= {KEY_W{1'b0}};
            r_par_cnt   <= {CNT_W{1'b0}};
            r_drop_cnt  <= {CNT_W{1'b0}};
        end else begin
            // Ready is withheld while the park is full, so accept and drain
            // of the park can never coincide.
            r_pkt_rdy  <= ~w_park_vld_nxt;
            r_park_vld <= w_park_vld_nxt;

            if (w_busy) begin
                if (w_good) begin
                    r_park_data <= w_evt_data;
                end
            end else if (r_park_vld) begin
                r_evt_data <= r_park_data;
                r_evt_vld  <= 1'b1;
            end else if (w_good) begin
                r_evt_data <= w_evt_data;
                r_evt_vld  <= 1'b1;
            end else begin
                r_evt_vld  <= 1'b0;
            end

            if (w_par_err && (r_par_cnt != CNT_MAX)) begin
                r_par_cnt <= r_par_cnt + CNT_W'(1'b1);
            end
            if (w_drop && (r_drop_cnt != CNT_MAX)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1'b1);
            end
        end
    end

    assign pkt_rdy_out     = r_pkt_rdy;
    assign evt_vld_out     = r_evt_vld;
    assign evt_data_out    = r_evt_data;
    assign par_err_cnt_out = r_par_cnt;
    assign drop_cnt_out    = r_drop_cnt;

endmodule

// File: tb/tb_pkt_disassembler.sv
// Directed self-checking bench for pkt_disassembler: filtering, field
// extraction, backpressure with parking, reset mid-stall and saturation.
module tb_pkt_disassembler;

    logic          clk;
    logic          reset;
    logic [31:0]   cfg_key_in;
    logic [31:0]   cfg_msk_in;
    logic [127:0]  field_msk_in;
    logic [23:0]   field_sft_in;
    logic [71:0]   pkt_data_in;
    logic          pkt_vld_in;
    logic          pkt_rdy_out;
    logic [31:0]   evt_data_out;
    logic          evt_vld_out;
    logic          evt_rdy_in;
    logic [15:0]   par_err_cnt_out;
    logic [15:0]   drop_cnt_out;

    int n_checks = 0;
    int n_pass   = 0;

    pkt_disassembler #(
        .NUM_FIELDS (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_key_in      (cfg_key_in),
        .cfg_msk_in      (cfg_msk_in),
        .field_msk_in    (field_msk_in),
        .field_sft_in    (field_sft_in),
        .pkt_data_in     (pkt_data_in),
        .pkt_vld_in      (pkt_vld_in),
        .pkt_rdy_out     (pkt_rdy_out),
        .evt_data_out    (evt_data_out),
        .evt_vld_out     (evt_vld_out),
        .evt_rdy_in      (evt_rdy_in),
        .par_err_cnt_out (par_err_cnt_out),
        .drop_cnt_out    (drop_cnt_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [71:0] p);
        pkt_data_in = p;
        pkt_vld_in  = 1'b1;
        step();
        pkt_vld_in  = 1'b0;
    endtask

    task automatic set_field(input int idx, input logic [31:0] msk, input logic [5:0] sft);
        field_msk_in[idx*32 +: 32] = msk;
        field_sft_in[idx*6 +: 6]   = sft;
    endtask

    // Builds a packet with header bit 0 chosen to give odd overall parity.
    function automatic logic [71:0] mk_pkt(input logic [31:0] pay, input logic [31:0] key,
                                           input logic [7:0] hdr);
        logic [71:0] p;
        p    = {pay, key, hdr[7:1], 1'b0};
        p[0] = ~(^p);
        return p;
    endfunction

    initial begin
        clk          = 1'b0;
        reset        = 1'b1;
        cfg_key_in   = 32'h1234_0000;
        cfg_msk_in   = 32'hFFFF_0000;
        field_msk_in = 128'h0;
        field_sft_in = 24'h0;
        pkt_data_in  = 72'h0;
        pkt_vld_in   = 1'b0;
        evt_rdy_in   = 1'b1;
        set_field(0, 32'h0000_FFFF, 6'd0);

        #12;
        check("rst_rdy",      {31'h0, pkt_rdy_out}, 32'h0);
        check("rst_evt_vld",  {31'h0, evt_vld_out}, 32'h0);
        check("rst_evt_data", evt_data_out, 32'h0);
        check("rst_par_cnt",  {16'h0, par_err_cnt_out}, 32'h0);
        check("rst_drop_cnt", {16'h0, drop_cnt_out}, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        step();
        check("rdy_after_rst", {31'h0, pkt_rdy_out}, 32'h1);

        // Basic acceptance: literal packet {0, 12340005, 00} has odd parity.
        send({32'h0, 32'h1234_0005, 8'h00});
        check("basic_vld",  {31'h0, evt_vld_out}, 32'h1);
        check("basic_evt",  evt_data_out, 32'h0000_0005);
        check("basic_par",  {16'h0, par_err_cnt_out}, 32'h0);
        check("basic_drop", {16'h0, drop_cnt_out}, 32'h0);
        step();
        check("basic_drain", {31'h0, evt_vld_out}, 32'h0);

        set_field(0, 32'h0000_000F, 6'b111100);
        send({32'h0, 32'h1234_0005, 8'h00});
        check("lsh4_evt", evt_data_out, 32'h0000_0050);

        set_field(0, 32'h0000_000F, 6'b100000);
        send({32'h0, 32'h1234_0005, 8'h00});
        check("sft_min_evt", evt_data_out, 32'h0000_0005);

        set_field(0, 32'hFFFF_0000, 6'd16);
        send({32'h0, 32'h1234_0005, 8'h00});
        check("rsh16_evt", evt_data_out, 32'h0000_1234);

        set_field(0, 32'h0000_000F, 6'd0);
        set_field(1, 32'h00FF_0000, 6'd8);
        send({32'h0, 32'h1234_0005, 8'h00});
        check("multi_evt", evt_data_out, 32'h0000_3405);

        set_field(1, 32'h0, 6'd0);
        set_field(0, 32'h0000_FFFF, 6'd0);
        send(mk_pkt(32'hDEAD_BEEF, 32'h1234_0005, 8'h02));
        check("ign_vld", {31'h0, evt_vld_out}, 32'h1);
        check("ign_evt", evt_data_out, 32'h0000_0005);

        send({32'h0, 32'h1234_0005, 8'h01});
        check("par_vld",  {31'h0, evt_vld_out}, 32'h0);
        check("par_cnt1", {16'h0, par_err_cnt_out}, 32'h1);
        check("par_drop", {16'h0, drop_cnt_out}, 32'h0);

        send({32'h0, 32'h5555_0000, 8'h01});
        check("key_vld",   {31'h0, evt_vld_out}, 32'h0);
        check("key_drop1", {16'h0, drop_cnt_out}, 32'h1);
        check("key_par",   {16'h0, par_err_cnt_out}, 32'h1);

        send({32'h0, 32'h1234_0005, 8'hC0});
        check("type_drop2", {16'h0, drop_cnt_out}, 32'h2);

        // Bad type and bad parity together: only the parity counter moves.
        send({32'h0, 32'h1234_0005, 8'h40});
        check("prio_par",  {16'h0, par_err_cnt_out}, 32'h2);
        check("prio_drop", {16'h0, drop_cnt_out}, 32'h2);

        evt_rdy_in  = 1'b0;
        pkt_data_in = mk_pkt(32'h0, 32'h1234_0001, 8'h00);
        pkt_vld_in  = 1'b1;
        step();
        check("bp_rdy1", {31'h0, pkt_rdy_out}, 32'h1);
        check("bp_evt1", evt_data_out, 32'h0000_0001);
        pkt_data_in = mk_pkt(32'h0, 32'h1234_0002, 8'h00);
        step();
        check("bp_rdy2",  {31'h0, pkt_rdy_out}, 32'h0);
        check("bp_hold1", evt_data_out, 32'h0000_0001);
        pkt_data_in = mk_pkt(32'h0, 32'h1234_0003, 8'h00);
        repeat (8) step();
        check("bp_stall_rdy",  {31'h0, pkt_rdy_out}, 32'h0);
        check("bp_stall_vld",  {31'h0, evt_vld_out}, 32'h1);
        check("bp_stall_data", evt_data_out, 32'h0000_0001);
        evt_rdy_in = 1'b1;
        step();
        check("bp_evt2",     evt_data_out, 32'h0000_0002);
        check("bp_evt2_vld", {31'h0, evt_vld_out}, 32'h1);
        check("bp_rdy_back", {31'h0, pkt_rdy_out}, 32'h1);
        step();
        pkt_vld_in = 1'b0;
        check("bp_evt3",     evt_data_out, 32'h0000_0003);
        check("bp_evt3_vld", {31'h0, evt_vld_out}, 32'h1);
        step();
        check("bp_empty", {31'h0, evt_vld_out}, 32'h0);
        check("bp_drop",  {16'h0, drop_cnt_out}, 32'h2);

        // Reset while an event is held and another is parked.
        evt_rdy_in = 1'b0;
        send(mk_pkt(32'h0, 32'h1234_0001, 8'h00));
        send(mk_pkt(32'h0, 32'h1234_0002, 8'h00));
        check("rs_pre_rdy", {31'h0, pkt_rdy_out}, 32'h0);
        reset = 1'b1;
        #1;
        check("rs_vld",  {31'h0, evt_vld_out}, 32'h0);
        check("rs_par",  {16'h0, par_err_cnt_out}, 32'h0);
        check("rs_drop", {16'h0, drop_cnt_out}, 32'h0);
        check("rs_rdy",  {31'h0, pkt_rdy_out}, 32'h0);
        #1;
        reset = 1'b0;
        step();
        check("rs_rdy_after", {31'h0, pkt_rdy_out}, 32'h1);
        check("rs_vld_after", {31'h0, evt_vld_out}, 32'h0);
        evt_rdy_in = 1'b1;
        send(mk_pkt(32'h0, 32'h1234_0007, 8'h00));
        check("rs_next_vld",  {31'h0, evt_vld_out}, 32'h1);
        check("rs_next_evt",  evt_data_out, 32'h0000_0007);
        check("rs_next_par",  {16'h0, par_err_cnt_out}, 32'h0);
        check("rs_next_drop", {16'h0, drop_cnt_out}, 32'h0);

        pkt_data_in = {32'h0, 32'h1234_0005, 8'h01};
        pkt_vld_in  = 1'b1;
        repeat (65534) step();
        check("sat_pre", {16'h0, par_err_cnt_out}, 32'h0000_FFFE);
        step();
        check("sat_hit", {16'h0, par_err_cnt_out}, 32'h0000_FFFF);
        repeat (4465) step();
        pkt_vld_in = 1'b0;
        check("sat_hold", {16'h0, par_err_cnt_out}, 32'h0000_FFFF);
        check("sat_drop", {16'h0, drop_cnt_out}, 32'h0);
        check("sat_vld",  {31'h0, evt_vld_out}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
